fc_argmax_classifier: RTL and testbench
=======================================

# fc_argmax_classifier

Downstream consumer of the fully connected PSRAM stage. Takes the packed vector of class scores that the FC stage produces on completion and scans it one element per cycle. Reports the winning class index, its score, the runner-up score, the top-1/top-2 margin and a confidence flag against a programmable threshold. Results are held under a valid/ready handshake until the keyword-spotting control logic accepts them.

## Interface
Parameters:
- NUM_CLASSES, 64, number of scores in the input vector (must be ≥ 2).
- ACTIV_BITS, 16, width of each score, two's-complement signed.
- IDX_BITS, 6, width of class index (≥ clog2(NUM_CLASSES)).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- scores_in  in  NUM_CLASSES*ACTIV_BITS  packed scores, element k at [k*ACTIV_BITS +: ACTIV_BITS].
- scores_valid  in  1  vector present; driven from the FC stage done pulse.
- in_ready  out  1  block idle and able to accept a vector.
- threshold  in  ACTIV_BITS  signed confidence threshold, sampled with the vector.
- class_idx  out  IDX_BITS  index of the maximum score.
- class_score  out  ACTIV_BITS  maximum score.
- runner_score  out  ACTIV_BITS  second-highest score.
- margin  out  ACTIV_BITS+1  class_score − runner_score, unsigned.
- confident  out  1  class_score ≥ threshold (signed compare).
- result_valid  out  1  result fields valid.
- result_ready  in  1  consumer accepts result.

## Operation
- States: IDLE, SCAN, RESULT.
- IDLE: in_ready=1. On scores_valid the block:
  - latches the full vector and threshold into internal registers;
  - sets best=elem0, best_idx=0, runner=most-negative (0x8000 for 16 bits), cnt=1;
  - moves to SCAN.
- SCAN: each cycle compares elem[cnt] against the running best and runner.
  - elem > best (strict): runner←best, best←elem, best_idx←cnt.
  - else if elem > runner: runner←elem.
  - Ties never displace best, so the lowest index wins. A value equal to best becomes runner, giving margin 0.
  - cnt increments each cycle. After processing cnt==NUM_CLASSES−1, the block goes to RESULT.
- On entry to RESULT, all output fields are registered from best, runner and threshold; result_valid=1.
  - margin is computed at ACTIV_BITS+1 width, so it does not overflow.
- RESULT: outputs are held stable while result_ready=0. result_valid && result_ready → IDLE, and result_valid drops the next cycle.
- scores_valid outside IDLE is ignored. The input vector is not re-read after it is latched, so upstream may change scores_in freely.
- Threshold is the value captured at acceptance; later changes do not affect the current result.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, in_ready=1, result_valid=0;
  - class_idx, class_score, runner_score, margin and confident all 0;
  - this applies from any state, including mid-SCAN. The partial result is discarded and no result_valid is produced.
- Acceptance: edge E0 where state=IDLE and scores_valid=1. in_ready=0 from the cycle after E0.
- Latency: result_valid rises after edge E0+NUM_CLASSES−1, which is 63 edges for 64 classes. The latency does not depend on the data.
- Handshake completion: at edge ER where result_valid && result_ready, state returns to IDLE. in_ready=1 in the next cycle, and a new vector can be accepted at ER+1.
- Minimum period between accepted vectors: NUM_CLASSES+1 cycles with result_ready held high.
- Output fields keep their last value after the handshake until the next RESULT entry. Only result_valid conveys validity.

## Structure
- Package fc_cls_pkg holds:
  - the state enum (IDLE/SCAN/RESULT);
  - the MOST_NEG constant function of ACTIV_BITS;
  - a default ACTIV_BITS localparam shared with fully_connected_psram integration.
- Sub-module argmax_update: a combinational compare/update of (elem, idx, best, best_idx, runner) → next values. It is instantiated once so that a parallel-tree variant can reuse it later.
- Element selection from the latched vector uses an indexed part-select driven by cnt. No per-class register file is required beyond the latched vector.

## Test plan
- Unique max: all scores 0x0010 except elem37=0x1234 and elem3=0x0800, threshold 0x1000 → class_idx=37, class_score=0x1234, runner=0x0800, margin=0x0A34, confident=1, result_valid 63 edges after acceptance.
- Tie: elem5=elem20=0x0400, all others 0x0001 → class_idx=5, runner_score=0x0400, margin=0.
- All negative: elem k = −100−k, threshold 0 → class_idx=0, class_score=−100 (0xFF9C), runner=−101, margin=1, confident=0.
- Backpressure: result_ready low for 10 cycles after result_valid → outputs stable, in_ready=0, and a scores_valid pulse during hold is ignored. After the ready handshake, in_ready=1 on the next cycle.
- Reset mid-scan: rst_n low at cycle 20 of SCAN → all outputs 0 and in_ready=1 the next cycle. A new vector with max at elem63 then yields class_idx=63.
- Back-to-back: two vectors with result_ready tied high → second accepted exactly NUM_CLASSES+1 cycles after the first, each with the correct index.

Source files
------------

// File: rtl/fc_cls_pkg.sv
// Shared types and constants for the FC-stage argmax classifier.
package fc_cls_pkg;

  // Score width used by the fully_connected_psram integration.
  localparam int DEF_ACTIV_BITS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    RESULT = 2'd2
  } cls_state_e;

  // Bit pattern of the most negative two's-complement value of the given
  // width; callers keep the low 'bits' bits (1 followed by zeros).
  function automatic logic [63:0] most_neg(input int bits);
    most_neg = 64'd1 << (bits - 1);
  endfunction

endpackage

// File: rtl/argmax_update.sv
// One compare/update step of a running top-2 search. Ties never displace
// best, so the earliest index holding the maximum is kept, and an element
// equal to best lands in runner.
module argmax_update
  import fc_cls_pkg::*;
#(
  parameter int ACTIV_BITS = DEF_ACTIV_BITS,
  parameter int IDX_BITS   = 6
) (
  input  logic signed [ACTIV_BITS-1:0] elem,
  input  logic        [IDX_BITS-1:0]   idx,
  input  logic signed [ACTIV_BITS-1:0] best,
  input  logic        [IDX_BITS-1:0]   best_idx,
  input  logic signed [ACTIV_BITS-1:0] runner,
  output logic signed [ACTIV_BITS-1:0] best_nxt,
  output logic        [IDX_BITS-1:0]   best_idx_nxt,
  output logic signed [ACTIV_BITS-1:0] runner_nxt
);

  // Strict compares: a new best demotes the old best to runner.
  always_comb begin
    best_nxt     = best;
    best_idx_nxt = best_idx;
    runner_nxt   = runner;
    if (elem > best) begin
      runner_nxt   = best;
      best_nxt     = elem;
      best_idx_nxt = idx;
    end else if (elem > runner) begin
      runner_nxt = elem;
    end
  end

endmodule

// File: rtl/fc_argmax_classifier.sv
// Sequential argmax over the FC-stage score vector: latches the vector,
// scans one element per cycle, and holds index/score/runner/margin/confidence
// under a valid/ready handshake.
module fc_argmax_classifier
  import fc_cls_pkg::*;
#(
  parameter int NUM_CLASSES = 64,
  parameter int ACTIV_BITS  = DEF_ACTIV_BITS,
  parameter int IDX_BITS    = 6
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CLASSES*ACTIV_BITS-1:0] scores_in,
  input  logic                              scores_valid,
  output logic                              in_ready,
  input  logic [ACTIV_BITS-1:0]             threshold,
  output logic [IDX_BITS-1:0]               class_idx,
  output logic [ACTIV_BITS-1:0]             class_score,
  output logic [ACTIV_BITS-1:0]             runner_score,
  output logic [ACTIV_BITS:0]               margin,
  output logic                              confident,
  output logic                              result_valid,
  input  logic                              result_ready
);

  localparam int                            VEC_W    = NUM_CLASSES * ACTIV_BITS;
  localparam logic [IDX_BITS-1:0]           LAST_IDX = IDX_BITS'(NUM_CLASSES - 1);
  localparam logic signed [ACTIV_BITS-1:0]  MOST_NEG = ACTIV_BITS'(most_neg(ACTIV_BITS));

  cls_state_e state_q, state_d;

  logic [VEC_W-1:0]               vec_q;
  logic signed [ACTIV_BITS-1:0]   thr_q;
  logic signed [ACTIV_BITS-1:0]   best_q, runner_q;
  logic [IDX_BITS-1:0]            best_idx_q, cnt_q;

  logic signed [ACTIV_BITS-1:0]   elem;
  logic signed [ACTIV_BITS-1:0]   best_nxt, runner_nxt;
  logic [IDX_BITS-1:0]            best_idx_nxt;
  logic [ACTIV_BITS:0]            margin_nxt;
  logic                           last_elem;

  // Element under inspection comes straight from the latched vector.
  assign elem      = vec_q[32'(cnt_q) * ACTIV_BITS +: ACTIV_BITS];
  assign last_elem = (cnt_q == LAST_IDX);

  argmax_update #(
    .ACTIV_BITS (ACTIV_BITS),
    .IDX_BITS   (IDX_BITS)
  ) u_upd (
    .elem         (elem),
    .idx          (cnt_q),
    .best         (best_q),
    .best_idx     (best_idx_q),
    .runner       (runner_q),
    .best_nxt     (best_nxt),
    .best_idx_nxt (best_idx_nxt),
    .runner_nxt   (runner_nxt)
  );

  // Sign-extend both operands one bit so the difference cannot overflow;
  // best >= runner always, so the result is a plain unsigned magnitude.
  assign margin_nxt = {best_nxt[ACTIV_BITS-1], best_nxt}
                    - {runner_nxt[ACTIV_BITS-1], runner_nxt};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    result_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (scores_valid) state_d = SCAN;
      end
      SCAN: begin
        if (last_elem) state_d = RESULT;
      end
      RESULT: begin
        result_valid = 1'b1;
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Vector and threshold capture; never re-read from the ports after accept.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && scores_valid) begin
      vec_q <= scores_in;
      thr_q <= threshold;
    end
  end

  // Running top-2 search and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      best_q       <= '0;
      best_idx_q   <= '0;
      runner_q     <= '0;
      cnt_q        <= '0;
      class_idx    <= '0;
      class_score  <= '0;
      runner_score <= '0;
      margin       <= '0;
      confident    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (scores_valid) begin
            best_q     <= scores_in[ACTIV_BITS-1:0];
            best_idx_q <= '0;
            runner_q   <= MOST_NEG;
            cnt_q      <= IDX_BITS'(1);
          end
        end
        SCAN: begin
          best_q     <= best_nxt;
          best_idx_q <= best_idx_nxt;
          runner_q   <= runner_nxt;
          cnt_q      <= cnt_q + 1'b1;
          // Final element: publish directly from the update outputs so the
          // result is ready the same edge the FSM enters RESULT.
          if (last_elem) begin
            class_idx    <= best_idx_nxt;
            class_score  <= best_nxt;
            runner_score <= runner_nxt;
            margin       <= margin_nxt;
            confident    <= (best_nxt >= thr_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Self-checking bench for fc_argmax_classifier: directed corner cases plus
// random vectors, all checked against a top-2 reference model.
module tb_fc_argmax_classifier;

  localparam int NC = 64;
  localparam int AB = 16;
  localparam int IB = 6;
  localparam int VW = NC * AB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [VW-1:0] scores_in;
  logic          scores_valid;
  logic          in_ready;
  logic [AB-1:0] threshold;
  logic [IB-1:0] class_idx;
  logic [AB-1:0] class_score;
  logic [AB-1:0] runner_score;
  logic [AB:0]   margin;
  logic          confident;
  logic          result_valid;
  logic          result_ready;

  int errs   = 0;
  int checks = 0;

  fc_argmax_classifier #(
    .NUM_CLASSES (NC),
    .ACTIV_BITS  (AB),
    .IDX_BITS    (IB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scores_in    (scores_in),
    .scores_valid (scores_valid),
    .in_ready     (in_ready),
    .threshold    (threshold),
    .class_idx    (class_idx),
    .class_score  (class_score),
    .runner_score (runner_score),
    .margin       (margin),
    .confident    (confident),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: best = largest value (earliest index on ties); runner = the
  // largest value among all other positions.
  function automatic void model(input logic [VW-1:0] v, output int idx,
                                output int best, output int runner);
    int e;
    best = -(1 << 30);
    idx  = 0;
    for (int k = 0; k < NC; k++) begin
      e = int'($signed(v[k*AB +: AB]));
      if (e > best) begin best = e; idx = k; end
    end
    runner = -(1 << 30);
    for (int k = 0; k < NC; k++) begin
      e = int'($signed(v[k*AB +: AB]));
      if (k != idx && e > runner) runner = e;
    end
  endfunction

  function automatic logic [VW-1:0] rand_vec(input bit narrow);
    logic [VW-1:0] v;
    for (int k = 0; k < NC; k++)
      v[k*AB +: AB] = narrow ? AB'($urandom_range(0, 4)) : AB'($urandom);
    return v;
  endfunction

  task automatic check_fields(input string tag, input logic [VW-1:0] v,
                              input logic [AB-1:0] thr);
    int idx, b, r;
    logic [IB-1:0] ei;
    logic [AB-1:0] es, er;
    logic [AB:0]   em;
    logic          ec;
    model(v, idx, b, r);
    ei = IB'(idx);
    es = AB'(b);
    er = AB'(r);
    em = (AB+1)'(b - r);
    ec = (b >= int'($signed(thr)));
    chk({tag, "_idx"},    class_idx,    ei);
    chk({tag, "_score"},  class_score,  es);
    chk({tag, "_runner"}, runner_score, er);
    chk({tag, "_margin"}, margin,       em);
    chk({tag, "_conf"},   confident,    ec);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_idle"}, in_ready, 1'b1);
  endtask

  // From the negedge after acceptance, count edges until result_valid.
  task automatic wait_result(input string tag);
    int lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!result_valid && lat < 200);
    chk({tag, "_lat"}, lat, NC - 1);
    chk({tag, "_rv"},  result_valid, 1'b1);
  endtask

  // Accept one vector, scramble the inputs, check the result, hold it for
  // 'hold' cycles (with an ignored scores_valid pulse), then hand it off.
  task automatic run_vec(input string tag, input logic [VW-1:0] v,
                         input logic [AB-1:0] thr, input int hold);
    wait_idle(tag);
    scores_in    = v;
    threshold    = thr;
    scores_valid = 1'b1;
    @(posedge clk);
    #1;
    scores_valid = 1'b0;
    scores_in    = rand_vec(1'b0);
    threshold    = ~thr;
    @(negedge clk);
    chk({tag, "_busy"}, in_ready, 1'b0);
    wait_result(tag);
    check_fields(tag, v, thr);
    for (int i = 0; i < hold; i++) begin
      scores_valid = (i == 3);
      @(negedge clk);
      scores_valid = 1'b0;
      chk({tag, "_hold_rv"}, result_valid, 1'b1);
      chk({tag, "_hold_rdy"}, in_ready, 1'b0);
      check_fields({tag, "_hold"}, v, thr);
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_done_rv"}, result_valid, 1'b0);
    chk({tag, "_done_rdy"}, in_ready, 1'b1);
    chk({tag, "_kept_idx"}, class_idx, dut.class_idx);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] v, v2;
    logic [AB-1:0] t;
    rst_n        = 1'b0;
    scores_in    = '0;
    scores_valid = 1'b0;
    threshold    = '0;
    result_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", in_ready, 1'b1);
    chk("rst_rv", result_valid, 1'b0);
    chk("rst_idx", class_idx, '0);
    chk("rst_score", class_score, '0);
    chk("rst_margin", margin, '0);
    rst_n = 1'b1;

    // Unique max with a distinct runner.
    for (int k = 0; k < NC; k++) v[k*AB +: AB] = 16'h0010;
    v[37*AB +: AB] = 16'h1234;
    v[3*AB +: AB]  = 16'h0800;
    run_vec("uniq", v, 16'h1000, 0);
    chk("uniq_const_idx", class_idx, 6'd37);
    chk("uniq_const_margin", margin, 17'h00A34);
    chk("uniq_const_conf", confident, 1'b1);

    // Tie for the max plus backpressure.
    for (int k = 0; k < NC; k++) v[k*AB +: AB] = 16'h0001;
    v[5*AB +: AB]  = 16'h0400;
    v[20*AB +: AB] = 16'h0400;
    run_vec("tie", v, 16'h0000, 10);
    chk("tie_const_idx", class_idx, 6'd5);
    chk("tie_const_margin", margin, 17'h0);

    // All negative, threshold zero.
    for (int k = 0; k < NC; k++) v[k*AB +: AB] = AB'(-100 - k);
    run_vec("neg", v, 16'h0000, 1);
    chk("neg_const_score", class_score, 16'hFF9C);
    chk("neg_const_conf", confident, 1'b0);

    // Reset in the middle of a scan.
    wait_idle("mrst");
    scores_in    = rand_vec(1'b0);
    scores_valid = 1'b1;
    @(posedge clk);
    #1;
    scores_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_rdy", in_ready, 1'b1);
    chk("mrst_rv", result_valid, 1'b0);
    chk("mrst_idx", class_idx, '0);
    chk("mrst_score", class_score, '0);
    chk("mrst_runner", runner_score, '0);
    chk("mrst_margin", margin, '0);
    chk("mrst_conf", confident, 1'b0);
    for (int k = 0; k < NC; k++) v[k*AB +: AB] = AB'(k);
    v[63*AB +: AB] = 16'h7FFF;
    run_vec("last", v, 16'h7FFF, 0);
    chk("last_const_idx", class_idx, 6'd63);

    // Back-to-back with result_ready high and scores_valid held.
    v  = rand_vec(1'b0);
    v2 = rand_vec(1'b1);
    t  = AB'($urandom);
    wait_idle("b2b");
    scores_in    = v;
    threshold    = t;
    scores_valid = 1'b1;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    scores_in = v2;
    @(negedge clk);
    wait_result("b2b_a");
    check_fields("b2b_a", v, t);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_hs_rv", result_valid, 1'b0);
    chk("b2b_hs_rdy", in_ready, 1'b1);
    @(posedge clk);
    #1;
    scores_valid = 1'b0;
    @(negedge clk);
    chk("b2b_accept65", in_ready, 1'b0);
    wait_result("b2b_b");
    check_fields("b2b_b", v2, t);
    @(posedge clk);
    #1;
    result_ready = 1'b0;

    // Random vectors, some with narrow ranges to force ties.
    for (int n = 0; n < 8; n++) begin
      v = rand_vec(n[0]);
      t = n[0] ? AB'($urandom_range(0, 5)) : AB'($urandom);
      run_vec($sformatf("rnd%0d", n), v, t, n % 4);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
